pc_sequencer: RTL and testbench

//   Next-PC controller for the fetch stage. Drives pc_in/pc_ena of the PC register block.

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle between the fetch-stage next-PC controller and its surroundings:
// PC register feedback and hazard/branch requests in, PC register and
// pipeline-latch controls out.
interface pc_sequencer_if;
    // From PC register and hazard/branch/exception logic
    logic [31:0] pc_cur;
    logic [31:0] pc_plus_1;
    logic        stall_req;
    logic        md_busy;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        halt;

    // To PC register, pipeline latches and status
    logic [31:0] pc_next;
    logic        pc_ena;
    logic        fd_flush;
    logic        dx_flush;
    logic        fetch_valid;
    logic        bad_addr;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    // Environment side: drives the requests, observes the controls.
    modport master (
        output pc_cur, pc_plus_1, stall_req, md_busy, redirect_valid,
               redirect_target, exc_req, halt,
        input  pc_next, pc_ena, fd_flush, dx_flush, fetch_valid, bad_addr,
               stall_cnt, state
    );

    // Sequencer side. pc_cur is only meaningful to the environment.
    modport slave (
        input  pc_plus_1, stall_req, md_busy, redirect_valid,
               redirect_target, exc_req, halt,
        output pc_next, pc_ena, fd_flush, dx_flush, fetch_valid, bad_addr,
               stall_cnt, state
    );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller for the fetch stage. Picks the next PC from the reset
// vector, PC+1, an execute-stage redirect or the exception vector, and
// drives stall/flush controls for the F/D and D/X latches, including halt.
module pc_sequencer #(
    parameter int unsigned ADDR_W       = 12,
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter logic [31:0] EXC_VECTOR   = 32'd1,
    parameter int unsigned FLUSH_CYCLES = 2      // legal 1..7
) (
    input logic           clock,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_e;

    // Down-counter start value: the counter reaches zero on the last squashed fetch.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_e      state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [31:0] pc_next_c;
    logic        pc_ena_c, fd_flush_c, dx_flush_c, fetch_valid_c, bad_addr_c;
    logic        stall_inc;
    logic        target_illegal;

    // Any set bit above the imem address range makes the redirect illegal.
    assign target_illegal = (bus.redirect_target >> ADDR_W) != 32'd0;

    // Next-state and output decode from the current state and requests.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        stall_inc     = 1'b0;
        pc_next_c     = bus.pc_plus_1;
        pc_ena_c      = 1'b0;
        fd_flush_c    = 1'b1;
        dx_flush_c    = 1'b1;
        fetch_valid_c = 1'b0;
        bad_addr_c    = 1'b0;

        if (reset) begin
            pc_next_c = RESET_PC;
        end else begin
            case (state_q)
                BOOT: begin
                    pc_next_c = RESET_PC;
                    pc_ena_c  = 1'b1;
                    state_d   = RUN;
                end
                RUN: begin
                    fetch_valid_c = 1'b1;
                    if (bus.exc_req || (bus.redirect_valid && target_illegal)) begin
                        // An illegal redirect is turned into an exception.
                        pc_next_c   = EXC_VECTOR;
                        pc_ena_c    = 1'b1;
                        bad_addr_c  = !bus.exc_req;
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (bus.redirect_valid) begin
                        pc_next_c   = bus.redirect_target;
                        pc_ena_c    = 1'b1;
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (bus.halt) begin
                        state_d = HALT;
                    end else if (bus.stall_req || bus.md_busy) begin
                        // F/D holds its instruction; a bubble goes into D/X.
                        fd_flush_c = 1'b0;
                        stall_inc  = 1'b1;
                    end else begin
                        pc_ena_c   = 1'b1;
                        fd_flush_c = 1'b0;
                        dx_flush_c = 1'b0;
                    end
                end
                FLUSH: begin
                    // Wrong-path fetches: redirect, halt and stall_req are ignored.
                    dx_flush_c = 1'b0;
                    if (bus.exc_req) begin
                        pc_next_c   = EXC_VECTOR;
                        pc_ena_c    = 1'b1;
                        dx_flush_c  = 1'b1;
                        flush_cnt_d = FLUSH_LOAD;
                    end else if (bus.md_busy) begin
                        stall_inc = 1'b1;
                    end else begin
                        pc_ena_c = 1'b1;
                        if (flush_cnt_q == 3'd0) begin
                            state_d = RUN;
                        end else begin
                            flush_cnt_d = flush_cnt_q - 3'd1;
                        end
                    end
                end
                HALT: begin
                    if (bus.exc_req) begin
                        pc_next_c   = EXC_VECTOR;
                        pc_ena_c    = 1'b1;
                        state_d     = FLUSH;
                        flush_cnt_d = FLUSH_LOAD;
                    end
                end
                default: state_d = BOOT;
            endcase
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_inc && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // State, squash counter and stall counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
        if (reset) begin
            state_q     <= BOOT;
            flush_cnt_q <= 3'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.pc_next     = pc_next_c;
    assign bus.pc_ena      = pc_ena_c;
    assign bus.fd_flush    = fd_flush_c;
    assign bus.dx_flush    = dx_flush_c;
    assign bus.fetch_valid = fetch_valid_c;
    assign bus.bad_addr    = bad_addr_c;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each
// cycle's controls as stimulus is issued; a monitor compares them mid-cycle.
`timescale 1ns/1ps
module tb_pc_sequencer;

    localparam int unsigned ADDR_W       = 12;
    localparam logic [31:0] RESET_PC     = 32'd0;
    localparam logic [31:0] EXC_VECTOR   = 32'd1;
    localparam int          FLUSH_CYCLES = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .RESET_PC    (RESET_PC),
        .EXC_VECTOR  (EXC_VECTOR),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // PC register around the sequencer (not reset, as in the real fetch stage).
    logic [31:0] pc_reg = 32'h0000_0ABC;
    always @(posedge clock) if (bus.pc_ena) pc_reg <= bus.pc_next;
    assign bus.pc_cur    = pc_reg;
    assign bus.pc_plus_1 = pc_reg + 32'd1;

    typedef struct {
        logic [31:0] pc_cur;
        logic [31:0] pc_next;
        bit          chk_pc;
        bit          pc_ena, fd, dx, chk_dx, fv, bad;
        logic [15:0] cnt;
        bit          chk_cnt;
        logic [1:0]  state;
        bit          chk_state;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: plain phase flags and counts.
    bit          m_known  = 1'b0;
    bit          m_boot   = 1'b1;
    bit          m_halt   = 1'b0;
    int          m_squash = 0;       // squashed fetches still to come
    int          m_stalls = 0;
    bit          m_cnt_en = 1'b0;    // stall count is compared until a halt is taken
    logic [31:0] mdl_pc   = 32'h0000_0ABC;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and push the model's prediction for it.
    task automatic step(input bit rst, input bit stl, input bit md, input bit rv,
                        input logic [31:0] rt, input bit exc, input bit hlt);
        exp_t e;
        @(posedge clock);
        #1;
        reset               = rst;
        bus.stall_req       = stl;
        bus.md_busy         = md;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.exc_req         = exc;
        bus.halt            = hlt;

        e.pc_cur    = mdl_pc;
        e.chk_state = m_known;
        e.state     = m_boot ? 2'd0 : m_halt ? 2'd3 : (m_squash > 0) ? 2'd2 : 2'd1;
        e.cnt       = 16'(m_stalls);
        e.chk_cnt   = m_known && m_cnt_en;
        e.pc_next   = 32'd0;
        e.chk_pc    = 1'b0;
        e.pc_ena    = 1'b0;
        e.fd        = 1'b1;
        e.dx        = 1'b1;
        e.chk_dx    = 1'b1;
        e.fv        = 1'b0;
        e.bad       = 1'b0;

        if (rst) begin
            e.pc_next = RESET_PC; e.chk_pc = 1'b1;
            m_known = 1'b1; m_boot = 1'b1; m_halt = 1'b0;
            m_squash = 0; m_stalls = 0; m_cnt_en = 1'b1;
        end else if (m_boot) begin
            e.pc_next = RESET_PC; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
            m_boot = 1'b0;
        end else if (m_halt) begin
            if (exc) begin
                e.pc_next = EXC_VECTOR; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
                m_halt = 1'b0; m_squash = FLUSH_CYCLES;
            end
        end else if (m_squash > 0) begin
            e.chk_dx = 1'b0;
            if (exc) begin
                e.pc_next = EXC_VECTOR; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
                e.chk_dx = 1'b1;
                m_squash = FLUSH_CYCLES;
            end else if (md) begin
                if (m_stalls < 65535) m_stalls++;
            end else begin
                e.pc_next = mdl_pc + 32'd1; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
                m_squash--;
            end
        end else begin
            e.fv = 1'b1;
            if (exc) begin
                e.pc_next = EXC_VECTOR; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
                m_squash = FLUSH_CYCLES;
            end else if (rv) begin
                e.bad     = (rt >= (32'd1 << ADDR_W));
                e.pc_next = e.bad ? EXC_VECTOR : rt;
                e.chk_pc  = 1'b1; e.pc_ena = 1'b1;
                m_squash  = FLUSH_CYCLES;
            end else if (hlt) begin
                e.chk_dx = 1'b0;
                m_halt = 1'b1; m_cnt_en = 1'b0;
            end else if (stl || md) begin
                e.fd = 1'b0;
                if (m_stalls < 65535) m_stalls++;
            end else begin
                e.pc_next = mdl_pc + 32'd1; e.chk_pc = 1'b1; e.pc_ena = 1'b1;
                e.fd = 1'b0; e.dx = 1'b0;
            end
        end

        if (e.pc_ena) mdl_pc = e.pc_next;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 32'd0, 0, 0);
    endtask

    // Advance until the next cycle's pc_cur is the target; bounded.
    task automatic run_until(input logic [31:0] target);
        int n = 0;
        while (mdl_pc != target && n < 200) begin
            idle(1);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL reach_pc: model stuck at %h, wanted %h", mdl_pc, target);
        end
    endtask

    // Monitor: compares the DUT against the oldest prediction mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("pc_cur", bus.pc_cur, e.pc_cur);
                if (e.chk_pc)    check("pc_next", bus.pc_next, e.pc_next);
                check("pc_ena", 32'(bus.pc_ena), 32'(e.pc_ena));
                check("fd_flush", 32'(bus.fd_flush), 32'(e.fd));
                if (e.chk_dx)    check("dx_flush", 32'(bus.dx_flush), 32'(e.dx));
                check("fetch_valid", 32'(bus.fetch_valid), 32'(e.fv));
                check("bad_addr", 32'(bus.bad_addr), 32'(e.bad));
                if (e.chk_cnt)   check("stall_cnt", 32'(bus.stall_cnt), 32'(e.cnt));
                if (e.chk_state) check("state", 32'(bus.state), 32'(e.state));
            end
        end
    end

    initial begin
        bus.stall_req       = 1'b0;
        bus.md_busy         = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;
        bus.exc_req         = 1'b0;
        bus.halt            = 1'b0;

        // Reset, boot, sequential fetch 0,1,2,...
        repeat (3) step(1, 0, 0, 0, 32'd0, 0, 0);
        idle(1);
        run_until(32'd5);
        // Redirect to 40: two squashed fetches, then real ones.
        step(0, 0, 0, 1, 32'd40, 0, 0);
        idle(3);
        // Back to 6 so that RUN resumes at 8 for the stall test.
        step(0, 0, 0, 1, 32'd6, 0, 0);
        idle(2);
        repeat (3) step(0, 1, 0, 0, 32'd0, 0, 0);
        idle(1);
        // Redirect beats a simultaneous stall; then an illegal target.
        step(0, 1, 0, 1, 32'h0000_0FF0, 0, 0);
        idle(2);
        step(0, 0, 0, 1, 32'h0000_1000, 0, 0);
        idle(2);
        // Halt at 12: frozen against everything except exc_req.
        run_until(32'd12);
        step(0, 0, 0, 0, 32'd0, 0, 1);
        for (int i = 0; i < 10; i++)
            step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom, 0, $urandom_range(0, 1));
        step(0, 0, 0, 0, 32'd0, 1, 0);
        idle(4);
        // Reset in the first squash cycle: straight back to BOOT.
        step(0, 0, 0, 1, 32'h0000_0123, 0, 0);
        step(1, 0, 0, 0, 32'd0, 0, 0);
        idle(4);
        // Stall counter saturation.
        repeat (65540) step(0, 1, 0, 0, 32'd0, 0, 0);
        idle(2);
        step(1, 0, 0, 0, 32'd0, 0, 0);
        idle(2);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            rt = ($urandom_range(0, 3) == 0) ? ($urandom | 32'h0000_1000) : ($urandom & 32'h0000_0FFF);
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0,
                 rt,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0);
        end

        idle(2);
        @(negedge clock);
        @(negedge clock);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
